// File: rtl/seven_seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seven_seg_pkg                                                   |
// | Purpose  : Shared types and constants for the seven-segment display driver |
// |            - FSM state enum                                                |
// |            - active-high glyph patterns (bit 0..6 = a..g, no dp)           |
// |            - BCD digit width                                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package seven_seg_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_UPDATE  = 2'd2
  } state_e;

  // Patterns are {g,f,e,d,c,b,a}, a lit segment is 1.
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

endpackage
`default_nettype wire

// File: rtl/seven_segment_glyph.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seven_segment_glyph                                             |
// | Purpose  : Combinational nibble-to-glyph decoder for one display digit     |
// | Ports    : nibble   in  4  digit value                                     |
// |            hex_mode in  1  1 = show A..F, 0 = decimal only                 |
// |            blank    in  1  force digit dark                                |
// |            dash     in  1  show a dash (wins over blank)                   |
// |            glyph    out 7  active-high segments a..g                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seven_segment_glyph
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    if (dash) begin
      glyph = GLYPH_DASH;
    end else if (!blank) begin
      case (nibble)
        4'h0:    glyph = GLYPH_0;
        4'h1:    glyph = GLYPH_1;
        4'h2:    glyph = GLYPH_2;
        4'h3:    glyph = GLYPH_3;
        4'h4:    glyph = GLYPH_4;
        4'h5:    glyph = GLYPH_5;
        4'h6:    glyph = GLYPH_6;
        4'h7:    glyph = GLYPH_7;
        4'h8:    glyph = GLYPH_8;
        4'h9:    glyph = GLYPH_9;
        // Letters only make sense in hex mode; a decimal digit never
        // exceeds 9, so this is purely defensive.
        4'hA:    glyph = hex_mode ? GLYPH_A : GLYPH_BLANK;
        4'hB:    glyph = hex_mode ? GLYPH_B : GLYPH_BLANK;
        4'hC:    glyph = hex_mode ? GLYPH_C : GLYPH_BLANK;
        4'hD:    glyph = hex_mode ? GLYPH_D : GLYPH_BLANK;
        4'hE:    glyph = hex_mode ? GLYPH_E : GLYPH_BLANK;
        default: glyph = hex_mode ? GLYPH_F : GLYPH_BLANK;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/seven_segment_display_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seven_segment_display_driver                                    |
// | Purpose  : Multi-digit seven-segment driver. Accepts a binary value over a |
// |            valid/ready handshake, converts it to BCD one bit per clock     |
// |            (shift-add-3) or uses hex nibbles directly, and drives          |
// |            registered glyphs with leading-zero blanking, decimal points,   |
// |            overflow dashes and optional blinking.                          |
// | Ports    : clk, reset (async, active-high)                                 |
// |            value_in/value_valid/value_ready  value handshake               |
// |            hex_mode, blank_lz, dp_in         sampled on accept             |
// |            blink_en                          live blink enable             |
// |            overflow                          last value not representable  |
// |            segments                          digit i at [8i+7:8i], bit7=dp |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seven_segment_display_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_WIDTH = 20,
  parameter int ACTIVE_LOW = 1,
  parameter int BLINK_DIV  = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blink_en,
  output logic                    overflow,
  output logic [8*NUM_DIGITS-1:0] segments
);

  localparam int BCD_W = BCD_DIGIT_W * NUM_DIGITS;
  localparam int EXT_W = (DATA_WIDTH > BCD_W) ? DATA_WIDTH : BCD_W;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  state_e                         state_q, state_d;
  logic [BCD_W-1:0]               bcd_q, bcd_d;
  logic [DATA_WIDTH-1:0]          bin_q, bin_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           sticky_q, sticky_d;
  logic                           hex_mode_q, hex_mode_d;
  logic                           blank_lz_q, blank_lz_d;
  logic [NUM_DIGITS-1:0]          dp_q, dp_d;
  logic                           overflow_q, overflow_d;
  logic [NUM_DIGITS-1:0][7:0]     glyph_q, glyph_d;
  logic [BLINK_DIV-1:0]           blink_q, blink_d;

  logic [EXT_W-1:0]               w_value_ext;
  logic [BCD_W-1:0]               w_bcd_adj;
  logic [NUM_DIGITS-1:0]          w_blank;
  logic [NUM_DIGITS-1:0][6:0]     w_glyph;
  logic                           w_zero_run;
  logic                           w_dark;

  assign value_ready = (state_q == ST_IDLE);
  assign overflow    = overflow_q;

  // Zero-extend so the hex path works whether the value is wider or
  // narrower than the digit field.
  always_comb begin
    w_value_ext                 = '0;
    w_value_ext[DATA_WIDTH-1:0] = value_in;
  end

  // Shift-add-3 correction: any digit >= 5 would become >= 10 after the
  // doubling shift, so bias it by 3 to make the carry land in the next digit.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
    assign w_bcd_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W] =
      (bcd_q[BCD_DIGIT_W*i +: BCD_DIGIT_W] >= 4'd5) ?
      (bcd_q[BCD_DIGIT_W*i +: BCD_DIGIT_W] + 4'd3) :
       bcd_q[BCD_DIGIT_W*i +: BCD_DIGIT_W];
  end

  // A digit is blanked when it and every digit above it are zero.
  // Digit 0 always stays visible so a zero value still shows "0".
  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (bcd_q[BCD_DIGIT_W*i +: BCD_DIGIT_W] == 4'd0);
      w_blank[i] = blank_lz_q & w_zero_run & (i != 0);
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    seven_segment_glyph u_glyph (
      .nibble   (bcd_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .hex_mode (hex_mode_q),
      .blank    (w_blank[i]),
      .dash     (sticky_q),
      .glyph    (w_glyph[i])
    );
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    hex_mode_d = hex_mode_q;
    blank_lz_d = blank_lz_q;
    dp_d       = dp_q;
    overflow_d = overflow_q;
    glyph_d    = glyph_q;
    blink_d    = blink_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (value_valid) begin
          hex_mode_d = hex_mode;
          blank_lz_d = blank_lz;
          dp_d       = dp_in;
          if (hex_mode) begin
            // Hex nibbles go straight into the digit register; the sticky
            // flag doubles as the hex overflow so UPDATE is mode-agnostic.
            bcd_d    = w_value_ext[BCD_W-1:0];
            sticky_d = |(w_value_ext >> BCD_W);
            state_d  = ST_UPDATE;
          end else begin
            bcd_d    = '0;
            bin_d    = value_in;
            cnt_d    = CNT_W'(DATA_WIDTH);
            sticky_d = 1'b0;
            state_d  = ST_CONVERT;
          end
        end
      end

      ST_CONVERT: begin
        // A bit leaving the top digit means the value needs more digits
        // than the display has.
        sticky_d = sticky_q | w_bcd_adj[BCD_W-1];
        bcd_d    = {w_bcd_adj[BCD_W-2:0], bin_q[DATA_WIDTH-1]};
        bin_d    = {bin_q[DATA_WIDTH-2:0], 1'b0};
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_UPDATE;
        end
      end

      ST_UPDATE: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          glyph_d[i] = {dp_q[i], w_glyph[i]};
        end
        overflow_d = sticky_q;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
      hex_mode_q <= 1'b0;
      blank_lz_q <= 1'b0;
      dp_q       <= '0;
      overflow_q <= 1'b0;
      glyph_q    <= {NUM_DIGITS{1'b0, GLYPH_BLANK}};
      blink_q    <= '0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
      hex_mode_q <= hex_mode_d;
      blank_lz_q <= blank_lz_d;
      dp_q       <= dp_d;
      overflow_q <= overflow_d;
      glyph_q    <= glyph_d;
      blink_q    <= blink_d;
    end
  end

  // Blinking only masks the output; the glyph registers keep their content.
  assign w_dark = blink_en & blink_q[BLINK_DIV-1];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_out
    logic [7:0] w_lit;
    assign w_lit = w_dark ? 8'h00 : glyph_q[i];
    assign segments[8*i +: 8] = (ACTIVE_LOW != 0) ? ~w_lit : w_lit;
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_display_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seven_segment_display_driver                                 |
// | Purpose  : Self-checking bench: directed vector table, hand-written        |
// |            reset/blink sequences, randomized transactions against an       |
// |            arithmetic reference model.                                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seven_segment_display_driver;

  localparam int ND = 6;
  localparam int DW = 20;
  localparam logic [47:0] ALL_OFF = {48{1'b1}};

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] value_in = '0;
  logic          value_valid = 1'b0;
  logic          value_ready;
  logic          hex_mode = 1'b0;
  logic          blank_lz = 1'b0;
  logic [ND-1:0] dp_in = '0;
  logic          blink_en = 1'b0;
  logic          overflow;
  logic [47:0]   segments;

  int n_vec = 0;
  int n_bad = 0;
  int edges = 0;
  logic [47:0] prev_seg = ALL_OFF;
  logic        prev_ovf = 1'b0;

  always #5 clk = ~clk;

  seven_segment_display_driver #(
    .NUM_DIGITS (ND),
    .DATA_WIDTH (DW),
    .ACTIVE_LOW (1),
    .BLINK_DIV  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .hex_mode    (hex_mode),
    .blank_lz    (blank_lz),
    .dp_in       (dp_in),
    .blink_en    (blink_en),
    .overflow    (overflow),
    .segments    (segments)
  );

  // Clock edges seen since reset release: the blink phase is (edges/8) odd.
  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Active-low glyph bytes, dp off.
  function automatic logic [7:0] glyph_al(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90; 10: return 8'h88; 11: return 8'h83;
      12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  // Reference: returns {overflow, segments}, built from digit arithmetic.
  function automatic logic [48:0] model(input int unsigned v, input bit hx,
                                        input bit blz, input logic [5:0] dp);
    int unsigned base, lim, t;
    int          dig [ND];
    int          msd;
    bit          ovf;
    logic [47:0] seg;
    logic [7:0]  b;
    base = hx ? 16 : 10;
    lim  = 1;
    for (int i = 0; i < ND; i++) lim = lim * base;
    ovf = (v >= lim);
    t   = v;
    msd = 0;
    for (int i = 0; i < ND; i++) begin
      dig[i] = int'(t % base);
      t      = t / base;
      if (dig[i] != 0) msd = i;
    end
    for (int i = 0; i < ND; i++) begin
      if (ovf)                 b = 8'hBF;
      else if (blz && i > msd) b = 8'hFF;
      else                     b = glyph_al(dig[i]);
      if (dp[i]) b = b & 8'h7F;
      seg[8*i +: 8] = b;
    end
    return {ovf, seg};
  endfunction

  // One full transaction: offer, accept, watch busy period, check result.
  // While busy, valid stays high with junk inputs; the driver must ignore them.
  task automatic apply(input logic [DW-1:0] v, input bit hx, input bit blz,
                       input logic [5:0] dp, input logic [47:0] exp_seg,
                       input bit exp_ovf, input string tag);
    int busy;
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!value_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, " ready-before"}, 64'(value_ready), 64'd1);
    value_in = v; hex_mode = hx; blank_lz = blz; dp_in = dp; value_valid = 1'b1;
    @(posedge clk);
    #1;
    value_in = DW'($urandom); hex_mode = ~hx; blank_lz = ~blz; dp_in = ~dp;
    busy = 0;
    while (1) begin
      @(negedge clk);
      if (value_ready || busy >= 100) break;
      busy++;
      check({tag, " hold"}, {15'd0, prev_ovf, prev_seg}, {15'd0, overflow, segments});
    end
    value_valid = 1'b0;
    check({tag, " busy-cycles"}, 64'(busy), hx ? 64'd1 : 64'(DW + 1));
    check({tag, " segments"}, {16'd0, segments}, {16'd0, exp_seg});
    check({tag, " overflow"}, 64'(overflow), 64'(exp_ovf));
    prev_seg = exp_seg;
    prev_ovf = exp_ovf;
  endtask

  typedef struct {
    logic [DW-1:0] value;
    bit            hex;
    bit            blz;
    logic [5:0]    dp;
    logic [47:0]   seg;
    bit            ovf;
  } vec_t;

  vec_t vecs [11];

  initial begin : main
    logic [48:0] m;
    logic [DW-1:0] rv;
    bit          rhx, rblz;
    logic [5:0]  rdp;

    vecs[0]  = '{20'd123456,  1'b0, 1'b0, 6'b000000, 48'hF9A4B0999282, 1'b0};
    vecs[1]  = '{20'd42,      1'b0, 1'b1, 6'b000010, 48'hFFFFFFFF19A4, 1'b0};
    vecs[2]  = '{20'd1000000, 1'b0, 1'b0, 6'b000000, 48'hBFBFBFBFBFBF, 1'b1};
    vecs[3]  = '{20'd7,       1'b0, 1'b0, 6'b000000, 48'hC0C0C0C0C0F8, 1'b0};
    vecs[4]  = '{20'hABCDE,   1'b1, 1'b1, 6'b000000, 48'hFF8883C6A186, 1'b0};
    vecs[5]  = '{20'd0,       1'b0, 1'b1, 6'b000000, 48'hFFFFFFFFFFC0, 1'b0};
    vecs[6]  = '{20'h00000,   1'b1, 1'b0, 6'b111111, 48'h404040404040, 1'b0};
    vecs[7]  = '{20'd999999,  1'b0, 1'b0, 6'b000000, 48'h909090909090, 1'b0};
    vecs[8]  = '{20'd1000000, 1'b0, 1'b1, 6'b100001, 48'h3FBFBFBFBF3F, 1'b1};
    vecs[9]  = '{20'hFFFFF,   1'b1, 1'b0, 6'b000000, 48'hC08E8E8E8E8E, 1'b0};
    vecs[10] = '{20'd100,     1'b0, 1'b1, 6'b100000, 48'h7FFFFFF9C0C0, 1'b0};

    // Power-on reset
    #2 reset = 1'b1;
    #1;
    check("reset segments", {16'd0, segments}, {16'd0, ALL_OFF});
    check("reset ready", 64'(value_ready), 64'd1);
    check("reset overflow", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].value, vecs[i].hex, vecs[i].blz, vecs[i].dp,
            vecs[i].seg, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // Blink: phase toggles every 8 edges of the 4-bit counter
    apply(vecs[0].value, 1'b0, 1'b0, 6'd0, vecs[0].seg, 1'b0, "blink-load");
    @(negedge clk);
    blink_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      check($sformatf("blink c%0d", c), {16'd0, segments},
            {16'd0, (((edges / 8) % 2) == 1) ? ALL_OFF : vecs[0].seg});
      @(negedge clk);
    end
    blink_en = 1'b0;
    #1;
    check("blink off restore", {16'd0, segments}, {16'd0, vecs[0].seg});

    // Reset in the middle of a conversion, with overflow showing beforehand
    apply(vecs[2].value, 1'b0, 1'b0, 6'd0, vecs[2].seg, 1'b1, "pre-reset");
    @(negedge clk);
    value_in = 20'd123456; hex_mode = 1'b0; blank_lz = 1'b0; dp_in = '0;
    value_valid = 1'b1;
    @(posedge clk);
    #1 value_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst segments", {16'd0, segments}, {16'd0, ALL_OFF});
    check("midrst ready", 64'(value_ready), 64'd1);
    check("midrst overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    prev_seg = ALL_OFF;
    prev_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("postrst ready", 64'(value_ready), 64'd1);
    check("postrst segments", {16'd0, segments}, {16'd0, ALL_OFF});
    apply(vecs[3].value, 1'b0, 1'b0, 6'd0, vecs[3].seg, 1'b0, "postrst-7");

    // Randomized transactions against the arithmetic model
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 3))
        0:       rv = DW'($urandom_range(0, 99));
        1:       rv = DW'($urandom_range(999990, 1000010));
        default: rv = DW'($urandom_range(0, 1048575));
      endcase
      rhx  = 1'($urandom);
      rblz = 1'($urandom);
      rdp  = 6'($urandom);
      m = model(int'(rv), rhx, rblz, rdp);
      apply(rv, rhx, rblz, rdp, m[47:0], m[48], $sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
